// File: rtl/dp_ram_sync_pkg.sv
// Shared types and helpers for the synchronous dual-port RAM.
package dp_ram_sync_pkg;
  typedef enum logic {CLEAR, READY} clr_state_e;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  // Even parity: the stored bit makes the byte plus parity have an even count of ones.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/dp_ram_sync_clear.sv
// Post-reset clear sequencer: walks every word once, then releases the array.
module dp_ram_sync_clear
  import dp_ram_sync_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH-1);

  clr_state_e state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Leaving CLEAR on the last-word edge means no idle cycle before READY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_busy = 1'b0;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
        if (cnt == LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign clr_addr = cnt;
endmodule

// File: rtl/dp_ram_sync.sv
// True dual-port synchronous RAM with byte enables, collision arbitration and clear-on-reset.
// Optional per-byte parity storage/checking under `define DP_RAM_SYNC_PARITY_EN.
module dp_ram_sync
  import dp_ram_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 2**ADDR_WIDTH,
  parameter int RD_MODE    = RD_FIRST
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    en_a,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   din_a,
  output logic [DATA_WIDTH-1:0]   dout_a,
  output logic                    dout_valid_a,
  output logic                    parity_err_a,
  input  logic                    en_b,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   din_b,
  output logic [DATA_WIDTH-1:0]   dout_b,
  output logic                    dout_valid_b,
  output logic                    parity_err_b,
  output logic                    collision
);
  localparam int NB = DATA_WIDTH/8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;
  logic                  in_a, in_b, rd_a, rd_b, wr_a, wr_b, coll;
  logic [DATA_WIDTH-1:0] mask_a, mask_b, old_a, old_b, base_a, base_b, new_a, new_b;

  dp_ram_sync_clear #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_clear (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we)
  );

  assign in_a = {1'b0, addr_a} < DEPTH_L;
  assign in_b = {1'b0, addr_b} < DEPTH_L;
  assign rd_a = en_a && !init_busy && !we_a;
  assign rd_b = en_b && !init_busy && !we_b;
  assign wr_a = en_a && !init_busy && we_a && |be_a && in_a;
  assign wr_b = en_b && !init_busy && we_b && |be_b && in_b;
  assign coll = wr_a && wr_b && (addr_a == addr_b);

  // Both ports compute the final landed word, so a collision writes identical data twice.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      mask_a[8*i +: 8] = {8{be_a[i]}};
      mask_b[8*i +: 8] = {8{be_b[i]}};
    end
    old_a  = in_a ? mem[addr_a] : '0;
    old_b  = in_b ? mem[addr_b] : '0;
    base_a = coll ? ((old_a & ~mask_b) | (din_b & mask_b)) : old_a;
    new_a  = (base_a & ~mask_a) | (din_a & mask_a);
    base_b = (old_b & ~mask_b) | (din_b & mask_b);
    new_b  = coll ? ((base_b & ~mask_a) | (din_a & mask_a)) : base_b;
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr_b) mem[addr_b] <= new_b;
      if (wr_a) mem[addr_a] <= new_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_a       <= '0;
      dout_b       <= '0;
      dout_valid_a <= 1'b0;
      dout_valid_b <= 1'b0;
      collision    <= 1'b0;
    end else begin
      dout_valid_a <= rd_a;
      dout_valid_b <= rd_b;
      collision    <= coll;
      if (rd_a)                           dout_a <= old_a;
      else if (RD_MODE == WR_FIRST && wr_a) dout_a <= new_a;
      if (rd_b)                           dout_b <= old_b;
      else if (RD_MODE == WR_FIRST && wr_b) dout_b <= new_b;
    end
  end

`ifdef DP_RAM_SYNC_PARITY_EN
  logic [NB-1:0] par [MEM_DEPTH];
  logic [NB-1:0] pold_a, pold_b;

  function automatic logic [NB-1:0] word_par(input logic [DATA_WIDTH-1:0] w);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = byte_par(w[8*i +: 8]);
    return p;
  endfunction

  assign pold_a = in_a ? par[addr_a] : '0;
  assign pold_b = in_b ? par[addr_b] : '0;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par[clr_addr] <= '0;
    end else begin
      if (wr_b) par[addr_b] <= word_par(new_b);
      if (wr_a) par[addr_a] <= word_par(new_a);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_a <= 1'b0;
      parity_err_b <= 1'b0;
    end else begin
      parity_err_a <= rd_a && |(pold_a ^ word_par(old_a));
      parity_err_b <= rd_b && |(pold_b ^ word_par(old_b));
    end
  end
`else
  assign parity_err_a = 1'b0;
  assign parity_err_b = 1'b0;
`endif
endmodule

// File: tb/tb_dp_ram_sync.sv
// Randomized self-checking bench: an 8x256 read-first instance and a 32x12 write-first instance.
module tb_dp_ram_sync;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic       en_a, we_a, en_b, we_b, busy, dva, dvb, col, pea, peb;
  logic [0:0] be_a, be_b;
  logic [7:0] addr_a, addr_b, din_a, din_b, da, db;

  logic        w_en_a, w_we_a, w_en_b, w_we_b, w_busy, w_dva, w_dvb, w_col, w_pea, w_peb;
  logic [3:0]  w_be_a, w_be_b, w_addr_a, w_addr_b;
  logic [31:0] w_din_a, w_din_b, w_da, w_db;

  dp_ram_sync u8 (
    .clk(clk), .rst(rst), .init_busy(busy),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(da), .dout_valid_a(dva), .parity_err_a(pea),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(db), .dout_valid_b(dvb), .parity_err_b(peb), .collision(col));

  dp_ram_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_DEPTH(12), .RD_MODE(1)) u32 (
    .clk(clk), .rst(rst), .init_busy(w_busy),
    .en_a(w_en_a), .we_a(w_we_a), .be_a(w_be_a), .addr_a(w_addr_a), .din_a(w_din_a),
    .dout_a(w_da), .dout_valid_a(w_dva), .parity_err_a(w_pea),
    .en_b(w_en_b), .we_b(w_we_b), .be_b(w_be_b), .addr_b(w_addr_b), .din_b(w_din_b),
    .dout_b(w_db), .dout_valid_b(w_dvb), .parity_err_b(w_peb), .collision(w_col));

  // Reference state: memory contents and expected registered outputs.
  logic [7:0]  m8 [256];
  logic [31:0] m32 [12];
  logic [7:0]  ea_d, eb_d;
  logic        ea_v, eb_v, e_col;
  logic [31:0] xa_d, xb_d;
  logic        xa_v, xb_v, x_col;
  int n_chk = 0, n_pass = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 256; i++) m8[i] = 8'h00;
    for (int i = 0; i < 12; i++) m32[i] = 32'h0;
    ea_d = 0; eb_d = 0; ea_v = 0; eb_v = 0; e_col = 0;
    xa_d = 0; xb_d = 0; xa_v = 0; xb_v = 0; x_col = 0;
  endtask

  task automatic idle();
    en_a = 0; we_a = 0; be_a = 0; addr_a = 0; din_a = 0;
    en_b = 0; we_b = 0; be_b = 0; addr_b = 0; din_b = 0;
    w_en_a = 0; w_we_a = 0; w_be_a = 0; w_addr_a = 0; w_din_a = 0;
    w_en_b = 0; w_we_b = 0; w_be_b = 0; w_addr_b = 0; w_din_b = 0;
  endtask

  // One cycle on the 8-bit instance; A's write wins when both hit the same word.
  task automatic drive8(input logic pa_en, pa_we, pa_be, input logic [7:0] pa_ad, pa_d,
                        input logic pb_en, pb_we, pb_be, input logic [7:0] pb_ad, pb_d);
    en_a = pa_en; we_a = pa_we; be_a = pa_be; addr_a = pa_ad; din_a = pa_d;
    en_b = pb_en; we_b = pb_we; be_b = pb_be; addr_b = pb_ad; din_b = pb_d;
    ea_v = pa_en && !pa_we; if (ea_v) ea_d = m8[pa_ad];
    eb_v = pb_en && !pb_we; if (eb_v) eb_d = m8[pb_ad];
    e_col = pa_en && pa_we && pa_be && pb_en && pb_we && pb_be && (pa_ad == pb_ad);
    if (pb_en && pb_we && pb_be) m8[pb_ad] = pb_d;
    if (pa_en && pa_we && pa_be) m8[pa_ad] = pa_d;
    @(posedge clk); #1;
  endtask

  // One cycle on the 32-bit write-first instance (12 words, addresses 12..15 invalid).
  task automatic drive32(input logic pa_en, pa_we, input logic [3:0] pa_be, pa_ad, input logic [31:0] pa_d,
                         input logic pb_en, pb_we, input logic [3:0] pb_be, pb_ad, input logic [31:0] pb_d);
    logic oka, okb;
    w_en_a = pa_en; w_we_a = pa_we; w_be_a = pa_be; w_addr_a = pa_ad; w_din_a = pa_d;
    w_en_b = pb_en; w_we_b = pb_we; w_be_b = pb_be; w_addr_b = pb_ad; w_din_b = pb_d;
    xa_v = pa_en && !pa_we; if (xa_v) xa_d = (pa_ad < 12) ? m32[pa_ad] : 32'h0;
    xb_v = pb_en && !pb_we; if (xb_v) xb_d = (pb_ad < 12) ? m32[pb_ad] : 32'h0;
    oka = pa_en && pa_we && (pa_be != 0) && (pa_ad < 12);
    okb = pb_en && pb_we && (pb_be != 0) && (pb_ad < 12);
    x_col = oka && okb && (pa_ad == pb_ad);
    if (okb) m32[pb_ad] = merge(m32[pb_ad], pb_d, pb_be);
    if (oka) m32[pa_ad] = merge(m32[pa_ad], pa_d, pa_be);
    if (oka) xa_d = m32[pa_ad];
    if (okb) xb_d = m32[pb_ad];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int c8, c32, guard;
    idle(); rst = 1;
    repeat (2) @(posedge clk); #1;
    reset_model();
    n_chk++; if (busy !== 1'b1 || w_busy !== 1'b1) $display("FAIL reset init_busy: got %b/%b exp 1/1", busy, w_busy); else n_pass++;
    n_chk++; if ({da, db} !== 16'h0 || {w_da, w_db} !== 64'h0) $display("FAIL reset dout: got %h %h %h %h exp 0", da, db, w_da, w_db); else n_pass++;
    n_chk++; if ({dva, dvb, col, pea, peb, w_dva, w_dvb, w_col, w_pea, w_peb} !== 10'h0)
      $display("FAIL reset flags: got %b exp 0", {dva, dvb, col, pea, peb, w_dva, w_dvb, w_col, w_pea, w_peb}); else n_pass++;
    @(negedge clk); rst = 0;
    c8 = 0; c32 = 0; guard = 0;
    // Garbage writes while clearing must be ignored.
    while (busy && guard < 400) begin
      c8++; if (w_busy) c32++; guard++;
      en_a = 1; we_a = 1; be_a = 1; addr_a = 8'($urandom); din_a = 8'($urandom | 1);
      en_b = 1; we_b = 1; be_b = 1; addr_b = 8'($urandom); din_b = 8'($urandom | 1);
      @(negedge clk);
    end
    n_chk++; if (c8 !== 256) $display("FAIL clear_len8: got %0d cycles exp 256", c8); else n_pass++;
    n_chk++; if (c32 !== 12) $display("FAIL clear_len32: got %0d cycles exp 12", c32); else n_pass++;
    idle();
    // First READY cycle: a write must be accepted.
    drive8(1, 1, 1, 8'hFF, 8'h5A, 1, 0, 0, 8'h00, 8'h00);
    n_chk++; if (db !== eb_d || dvb !== 1'b1) $display("FAIL first_cycle rd: got %h/%b exp %h/1", db, dvb, eb_d); else n_pass++;
    for (int i = 0; i < 256; i++) begin
      drive8(1, 0, 0, 8'(i), 8'h00, 1, 0, 0, 8'(255 - i), 8'h00);
      n_chk++; if (da !== ea_d || dva !== 1'b1) $display("FAIL clear_rd_a[%0d]: got %h/%b exp %h/1", i, da, dva, ea_d); else n_pass++;
      n_chk++; if (db !== eb_d || dvb !== 1'b1) $display("FAIL clear_rd_b[%0d]: got %h/%b exp %h/1", 255 - i, db, dvb, eb_d); else n_pass++;
    end
  endtask

  task automatic test_write_read();
    drive8(1, 1, 1, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
    n_chk++; if (dva !== 1'b0) $display("FAIL wr_no_valid: got %b exp 0", dva); else n_pass++;
    drive8(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00);
    n_chk++; if (db !== 8'hA5 || dvb !== 1'b1) $display("FAIL wr_then_rd: got %h/%b exp a5/1", db, dvb); else n_pass++;
  endtask

  task automatic test_collision();
    drive8(1, 1, 1, 8'h20, 8'h11, 1, 1, 1, 8'h20, 8'h22);
    n_chk++; if (col !== 1'b1) $display("FAIL coll_pulse: got %b exp 1", col); else n_pass++;
    drive8(1, 0, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    n_chk++; if (col !== 1'b0) $display("FAIL coll_clear: got %b exp 0", col); else n_pass++;
    n_chk++; if (da !== 8'h11) $display("FAIL coll_winner: got %h exp 11", da); else n_pass++;
  endtask

  task automatic test_cross_rw();
    drive8(1, 1, 1, 8'h30, 8'h33, 1, 0, 0, 8'h30, 8'h00);
    n_chk++; if (db !== 8'h00 || dvb !== 1'b1) $display("FAIL cross_old: got %h/%b exp 00/1", db, dvb); else n_pass++;
    drive8(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h30, 8'h00);
    n_chk++; if (db !== 8'h33) $display("FAIL cross_new: got %h exp 33", db); else n_pass++;
  endtask

  task automatic test_wide();
    drive32(1, 1, 4'hF, 4'd3, 32'hDEADBEEF, 0, 0, 4'h0, 4'd0, 32'h0);
    n_chk++; if (w_da !== 32'hDEADBEEF || w_dva !== 1'b0) $display("FAIL wf_dout: got %h/%b exp deadbeef/0", w_da, w_dva); else n_pass++;
    drive32(1, 1, 4'b0001, 4'd3, 32'h000000FF, 0, 0, 4'h0, 4'd0, 32'h0);
    n_chk++; if (w_da !== 32'hDEADBEFF) $display("FAIL be_merge_wf: got %h exp deadbeff", w_da); else n_pass++;
    drive32(0, 0, 4'h0, 4'd0, 32'h0, 1, 0, 4'h0, 4'd3, 32'h0);
    n_chk++; if (w_db !== 32'hDEADBEFF || w_dvb !== 1'b1) $display("FAIL be_merge_rd: got %h/%b exp deadbeff/1", w_db, w_dvb); else n_pass++;
    drive32(1, 1, 4'hF, 4'd13, 32'h12345678, 0, 0, 4'h0, 4'd0, 32'h0);
    drive32(0, 0, 4'h0, 4'd0, 32'h0, 1, 0, 4'h0, 4'd13, 32'h0);
    n_chk++; if (w_db !== 32'h0 || w_dvb !== 1'b1) $display("FAIL oor_read: got %h/%b exp 0/1", w_db, w_dvb); else n_pass++;
    drive32(1, 1, 4'b0011, 4'd5, 32'h11111111, 1, 1, 4'b0110, 4'd5, 32'h22222222);
    drive32(1, 0, 4'h0, 4'd5, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0);
    n_chk++; if (w_da !== 32'h00221111 || w_col !== 1'b0) $display("FAIL part_coll: got %h/%b exp 00221111/0", w_da, w_col); else n_pass++;
    drive32(1, 1, 4'h0, 4'd5, 32'hFFFFFFFF, 0, 0, 4'h0, 4'd0, 32'h0);
    n_chk++; if (w_da !== 32'h00221111 || w_dva !== 1'b0) $display("FAIL be0_noop: got %h/%b exp 00221111/0", w_da, w_dva); else n_pass++;
  endtask

  task automatic test_random8();
    for (int i = 0; i < 300; i++) begin
      drive8(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 7)), 8'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 7)), 8'($urandom));
      n_chk++; if (da !== ea_d || dva !== ea_v) $display("FAIL rand8_a[%0d]: got %h/%b exp %h/%b", i, da, dva, ea_d, ea_v); else n_pass++;
      n_chk++; if (db !== eb_d || dvb !== eb_v) $display("FAIL rand8_b[%0d]: got %h/%b exp %h/%b", i, db, dvb, eb_d, eb_v); else n_pass++;
      n_chk++; if (col !== e_col || {pea, peb} !== 2'b00) $display("FAIL rand8_flags[%0d]: got %b%b%b exp %b00", i, col, pea, peb, e_col); else n_pass++;
    end
  endtask

  task automatic test_random32();
    for (int i = 0; i < 300; i++) begin
      drive32(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 13)), $urandom,
              1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 13)), $urandom);
      n_chk++; if (w_da !== xa_d || w_dva !== xa_v) $display("FAIL rand32_a[%0d]: got %h/%b exp %h/%b", i, w_da, w_dva, xa_d, xa_v); else n_pass++;
      n_chk++; if (w_db !== xb_d || w_dvb !== xb_v) $display("FAIL rand32_b[%0d]: got %h/%b exp %h/%b", i, w_db, w_dvb, xb_d, xb_v); else n_pass++;
      n_chk++; if (w_col !== x_col) $display("FAIL rand32_coll[%0d]: got %b exp %b", i, w_col, x_col); else n_pass++;
    end
  endtask

  task automatic test_midclear_reset();
    int c8, c32, guard;
    idle(); rst = 1;
    @(posedge clk); #1;
    @(negedge clk); rst = 0;
    repeat (100) @(negedge clk);
    n_chk++; if (busy !== 1'b1) $display("FAIL midclear_busy: got %b exp 1", busy); else n_pass++;
    rst = 1;
    @(negedge clk); rst = 0;
    reset_model();
    c8 = 0; c32 = 0; guard = 0;
    while (busy && guard < 400) begin
      c8++; if (w_busy) c32++; guard++;
      @(negedge clk);
    end
    n_chk++; if (c8 !== 256) $display("FAIL restart_len8: got %0d cycles exp 256", c8); else n_pass++;
    n_chk++; if (c32 !== 12) $display("FAIL restart_len32: got %0d cycles exp 12", c32); else n_pass++;
    drive8(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00);
    n_chk++; if (da !== 8'h00 || db !== 8'h00) $display("FAIL restart_zero: got %h %h exp 00 00", da, db); else n_pass++;
    drive32(1, 0, 4'h0, 4'd3, 32'h0, 1, 0, 4'h0, 4'd5, 32'h0);
    n_chk++; if (w_da !== 32'h0 || w_db !== 32'h0) $display("FAIL restart_zero32: got %h %h exp 0 0", w_da, w_db); else n_pass++;
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_collision();
    test_cross_rw();
    test_wide();
    test_random8();
    test_random32();
    test_midclear_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dp_ram_sync.md
# dp_ram_sync

Parametrised, fully synchronous true dual-port RAM for the processor memory subsystem; successor to the 8x256 combinational-read dual-port RAM. Adds configurable width/depth, registered reads with valid flags, per-byte write enables, deterministic write-collision arbitration, and a post-reset clear sequencer that zeroes the array before accepting traffic. Sits between the core's instruction/data ports and any second master (DMA, debug).

## Interface

Parameters:
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width in bits.
- MEM_DEPTH, 2**ADDR_WIDTH, number of words; must be at most 2**ADDR_WIDTH.
- RD_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous reset, active high.
- init_busy  out  1  high while the clear sequence runs; all port requests ignored.
- en_a / en_b  in  1  port access enable.
- we_a / we_b  in  1  write when en is high; read when en is high and we is low.
- be_a / be_b  in  DATA_WIDTH/8  byte write enables; bit i covers bits 8i+7:8i.
- addr_a / addr_b  in  ADDR_WIDTH  word address.
- din_a / din_b  in  DATA_WIDTH  write data.
- dout_a / dout_b  out  DATA_WIDTH  registered read data; holds until the next read on that port.
- dout_valid_a / dout_valid_b  out  1  one-cycle pulse with each new dout.
- collision  out  1  one-cycle pulse: both ports wrote the same address in the previous cycle.
- parity_err_a / parity_err_b  out  1  pulse with dout_valid on a parity mismatch (see Configuration).

## Operation

- Clear FSM states: CLEAR, READY. rst forces CLEAR and resets the clear counter to 0. In CLEAR, one word per cycle gets all bytes written to 0 at the counter address; the counter increments; after address MEM_DEPTH-1 the FSM moves to READY. Reaching READY takes no extra cycle.
- rst asserted mid-clear or in READY restarts the clear from address 0.
- In READY, each port is independent. Writes apply only the bytes whose be bit is set. be = 0 with we = 1 is a no-op write that produces no read.
- Reads return the addressed word one cycle later with dout_valid.
- Same-port write never produces dout_valid. With RD_MODE = 1, a write also updates dout to the merged word, but valid stays low.
- Cross-port read/write to the same address in the same cycle: the reader gets the old data. This is independent of RD_MODE.
- Both ports write the same address in the same cycle: port A's enabled bytes win. Port B's bytes not enabled on A still land. collision pulses the next cycle.
- Addresses at or above MEM_DEPTH: writes are dropped; reads return 0 with valid.
- Reset values: init_busy 1, dout_* 0, dout_valid_* 0, collision 0, parity_err_* 0.

## Timing

- Read latency: 1 cycle, addr/en sampled at edge N, dout/dout_valid updated at edge N+1.
- Write latency: 1 cycle; a read of the same address issued on the following cycle returns the new data.
- Clear duration: exactly MEM_DEPTH cycles after rst deasserts. init_busy falls on the edge that writes the last word. A request presented in the first cycle with init_busy low is accepted.
- Full throughput: one access per port per cycle, with no stalls in READY.

## Configuration

- DP_RAM_SYNC_PARITY_EN defined:
  - The array stores one even-parity bit per byte, written with each byte (clear writes parity 0).
  - On reads, parity is recomputed. Any byte mismatch raises parity_err_x alongside dout_valid_x. Data is returned unmodified.
- Not defined:
  - No parity storage or logic.
  - parity_err_a/b tied to 0.

## Structure

- Package dp_ram_sync_pkg holds:
  - the clear-FSM state enum (CLEAR, READY),
  - RD_MODE constants RD_FIRST = 0 and WR_FIRST = 1,
  - a byte-parity function.
- Sub-module dp_ram_sync_clear holds the clear counter and FSM. It outputs init_busy, the clear address and the clear write enable, which the top muxes onto the write path.

## Test plan

- Reset, then hold off for 256 cycles (default params) -> init_busy high for exactly 256 cycles; a read of every address afterwards returns 0.
- Write 0xA5 to address 0x10 on A, then read 0x10 on B next cycle -> dout_b = 0xA5 with dout_valid_b high one cycle later.
- Same cycle: A writes 0x11 and B writes 0x22 to address 0x20 -> collision pulses next cycle; a subsequent read returns 0x11.
- Same cycle: A writes 0x33 to 0x30 (old 0x00) and B reads 0x30 -> dout_b = 0x00; the next B read returns 0x33.
- DATA_WIDTH = 32: write 0xDEADBEEF, then write 0x000000FF with be = 4'b0001 -> read returns 0xDEADBEFF.
- Assert rst mid-clear at counter 100 -> the clear restarts at 0; init_busy stays high for a further 256 cycles.
